// File: rtl/uart_rx.sv
// UART receiver: 8N1 deframer (LSB first) with a one-entry valid/ready buffer and error pulses.
// Define UART_RX_PARITY_EN for 8E1 framing and the parity_err pulse output.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] recv_data,
    output logic       recv_valid,
    input  logic       recv_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   done_q, done_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic [7:0]             recv_data_q, recv_data_d;
    logic                   recv_valid_q, recv_valid_d;
    logic                   busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   parity_err_q, parity_err_d;
`endif

    logic rxs;
    assign rxs = sync_q[SYNC_STAGES-1];

    // Deframing FSM; all sampling decisions use the synchronized line only.
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], uart_rxd};
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        done_d       = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    if (rxs != ^shift_q) begin
                        par_bad_d    = 1'b1;
                        parity_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        done_d  = !par_bad_q;
`else
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d     = WAIT_IDLE;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) parks here without further error pulses.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // One-entry output buffer; a completed byte loads the cycle after the stop sample.
    always_comb begin
        recv_data_d  = recv_data_q;
        recv_valid_d = recv_valid_q;
        overrun_d    = 1'b0;

        if (recv_valid_q && recv_ready) begin
            recv_valid_d = 1'b0;
        end
        if (done_q) begin
            if (!recv_valid_q || recv_ready) begin
                recv_data_d  = shift_q;
                recv_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            recv_data_q  <= 8'h00;
            recv_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            recv_data_q  <= recv_data_d;
            recv_valid_q <= recv_valid_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign recv_data  = recv_data_q;
    assign recv_valid = recv_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
